// File: rtl/axi4_lite_master_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_master_if
//
// Bundles every signal of the AXI4-Lite initiator apart from clock and reset:
//   - command port   : cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata/cmd_wstrb
//   - response port  : rsp_valid/rsp_ready/rsp_we/rsp_rdata/rsp_resp
//   - AXI4-Lite bus  : AW, W, B, AR and R channels (M_AXI_* names)
//
// Modports:
//   master - the initiator's view (drives cmd_ready, rsp_*, AXI requests)
//   slave  - the opposite side (command source, response sink, AXI slave)
// ---------------------------------------------------------------------------
interface axi4_lite_master_if #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
);
  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  // Command port
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_we;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_W-1:0]             cmd_wstrb;

  // Response port
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic                          rsp_we;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]                    rsp_resp;

  // AXI4-Lite write address / data / response
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]                    M_AXI_AWPROT;
  logic                          M_AXI_AWVALID;
  logic                          M_AXI_AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [STRB_W-1:0]             M_AXI_WSTRB;
  logic                          M_AXI_WVALID;
  logic                          M_AXI_WREADY;
  logic [1:0]                    M_AXI_BRESP;
  logic                          M_AXI_BVALID;
  logic                          M_AXI_BREADY;

  // AXI4-Lite read address / data
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]                    M_AXI_ARPROT;
  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;
  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_we, rsp_rdata, rsp_resp,
    input  rsp_ready,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_we, rsp_rdata, rsp_resp,
    output rsp_ready,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_master.sv
// ---------------------------------------------------------------------------
// axi4_lite_master
//
// Converts single register read/write commands into AXI4-Lite transactions,
// one at a time, and returns read data plus BRESP/RRESP on a response port.
//
// Ports:
//   ACLK   - clock, all logic on the rising edge
//   ARSTn  - asynchronous active-low reset
//   bus    - axi4_lite_master_if.master: command port (cmd_*), response port
//            (rsp_*) and the five AXI4-Lite channels (M_AXI_*)
//
// Every AXI and response output comes straight from a flop; cmd_ready is a
// decode of the state register only.
// ---------------------------------------------------------------------------
module axi4_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input logic                ACLK,
  input logic                ARSTn,
  axi4_lite_master_if.master bus
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t                        state_q, state_d;

  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]             wstrb_q, wstrb_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          bready_q, bready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                          arvalid_q, arvalid_d;
  logic                          rready_q, rready_d;

  logic                          rsp_valid_q, rsp_valid_d;
  logic                          rsp_we_q, rsp_we_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                    rsp_resp_q, rsp_resp_d;

  // A write request channel is still pending if its VALID is up and the
  // slave has not taken it on this edge.
  logic                          aw_pending;
  logic                          w_pending;

  // State register
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    aw_pending  = awvalid_q & ~bus.M_AXI_AWREADY;
    w_pending   = wvalid_q & ~bus.M_AXI_WREADY;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_we) begin
            awaddr_d  = bus.cmd_addr;
            wdata_d   = bus.cmd_wdata;
            wstrb_d   = bus.cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = bus.cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        // AW and W retire independently; a channel already retired stays low.
        awvalid_d = aw_pending;
        wvalid_d  = w_pending;
        if (!aw_pending && !w_pending) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (bus.M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bus.M_AXI_BRESP;
          state_d     = DONE;
        end
      end

      RD_REQ: begin
        if (bus.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (bus.M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b0;
          rsp_rdata_d = bus.M_AXI_RDATA;
          rsp_resp_d  = bus.M_AXI_RRESP;
          state_d     = DONE;
        end
      end

      DONE: begin
        // Returning to IDLE (not accepting here) keeps cmd_ready a pure
        // state decode, so no command is taken on the response edge.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign bus.cmd_ready     = (state_q == IDLE);

  assign bus.M_AXI_AWADDR  = awaddr_q;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_BREADY  = bready_q;
  assign bus.M_AXI_ARADDR  = araddr_q;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = rready_q;

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_we        = rsp_we_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_resp      = rsp_resp_q;

endmodule
